// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan multiplexer: glyph table, blank pattern, index width.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g} patterns for hex digits 0..F
    localparam logic [6:0] SEG_GLYPH [0:15] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_GLYPH[nibble];

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment driver with per-slot anti-ghost blanking.
// Optional leading-zero blanking is compiled in by defining SEG7_LZB_EN.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 100000,
    parameter int GUARD_CYCLES = 2
) (
    input  logic                    real_clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_done
);

    localparam int IW = idx_width(NUM_DIGITS);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GUARD    = CW'(GUARD_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt_reg;
    logic [IW-1:0]           idx_reg;
    logic [4*NUM_DIGITS-1:0] snap_value_reg;
    logic [NUM_DIGITS-1:0]   snap_dp_reg;
    logic [6:0]              seg_reg, seg_next;
    logic                    dp_reg, dp_next;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    logic                    frame_done_reg;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              nib [NUM_DIGITS];
    logic [6:0]              glyph;

    assign tick = (cnt_reg == CNT_LAST);
    assign wrap = tick && (idx_reg == IDX_LAST);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign nib[gi] = snap_value_reg[4*gi +: 4];
        end
    endgenerate

    hex_to_seg7 u_dec (
        .nibble (nib[idx_reg]),
        .seg    (glyph)
    );

`ifdef SEG7_LZB_EN
    // zero_above[i]: nibble i and every nibble above it are zero
    logic [NUM_DIGITS-1:0] zero_above;
    logic                  lz_blank;

    always_comb begin
        logic run;
        run        = 1'b1;
        zero_above = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run           = run && (nib[i] == 4'h0);
            zero_above[i] = run;
        end
    end

    assign lz_blank = (idx_reg != '0) && zero_above[idx_reg];
    assign seg_next = lz_blank ? SEG_BLANK : glyph;
`else
    assign seg_next = glyph;
`endif

    always_comb begin
        an_next = '1;
        if (digit_en[idx_reg] && (cnt_reg >= GUARD)) begin
            an_next[idx_reg] = 1'b0;
        end
        dp_next = ~snap_dp_reg[idx_reg];
    end

    always_ff @(posedge real_clk) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            snap_value_reg <= '0;
            snap_dp_reg    <= '0;
            seg_reg        <= SEG_BLANK;
            dp_reg         <= 1'b1;
            an_reg         <= '1;
            frame_done_reg <= 1'b0;
        end else begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
            if (tick) begin
                idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
            end
            // New inputs become visible only at frame boundaries
            if (wrap) begin
                snap_value_reg <= value;
                snap_dp_reg    <= dp_in;
            end
            frame_done_reg <= wrap;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            an_reg         <= an_next;
        end
    end

    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign an         = an_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed digits, legal 1..8.
REQ-002 SHALL have parameter CLK_DIV, default 100000, real_clk cycles per digit slot, legal >= 4.
REQ-003 SHALL have parameter GUARD_CYCLES, default 2, anti-ghost blanking cycles at the start of each slot, legal 0..CLK_DIV-1.
REQ-004 SHALL have real_clk  input  1  sole clock, all state on the rising edge.
REQ-005 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have value  input  4*NUM_DIGITS  hex nibbles; nibble i drives digit i, digit 0 rightmost.
REQ-007 SHALL have dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = lit.
REQ-008 SHALL have digit_en  input  NUM_DIGITS  per-digit enable; 0 keeps that anode off.
REQ-009 SHALL have seg  output  7  segments {a,b,c,d,e,f,g} in bits 6..0, active-low.
REQ-010 SHALL have dp  output  1  decimal point, active-low.
REQ-011 SHALL have an  output  NUM_DIGITS  anodes, active-low, at most one low.
REQ-012 SHALL have frame_done  output  1  one-cycle pulse when a full scan frame completes.

Function
REQ-013 Prescaler cnt SHALL count 0..CLK_DIV-1 and wrap to 0; tick asserts in the cycle cnt==CLK_DIV-1.
REQ-014 On tick, digit index idx SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0; NUM_DIGITS=1 keeps idx at 0.
REQ-015 value and dp_in SHALL be captured into a snapshot only on the tick where idx wraps to 0; mid-frame input changes SHALL NOT appear before the next frame.
REQ-016 frame_done SHALL be registered high for exactly the one cycle after the wrap tick of REQ-015.
REQ-017 seg, dp and an SHALL be registered, reflecting the previous cycle's cnt, idx and snapshot (1-cycle latency).
REQ-018 an bit idx SHALL be low iff digit_en[idx]==1 and cnt >= GUARD_CYCLES; all other bits high.
REQ-019 seg SHALL decode snapshot nibble idx: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-020 dp SHALL equal ~snapshot_dp[idx].
REQ-021 During guard cycles or a disabled digit, seg and dp SHALL still follow REQ-019/020; only an is suppressed.
REQ-022 digit_en SHALL be sampled live every cycle, not snapshotted.

Reset
REQ-023 While rst_n==0 at a clock edge: cnt=0, idx=0, snapshot=0, an=all ones, seg=1111111, dp=1, frame_done=0.
REQ-024 Reset asserted mid-frame SHALL take effect at the next edge, discarding the partial frame; the first frame after release shows snapshot 0 until the first wrap tick.

Configuration
REQ-025 Macro SEG7_LZB_EN SHALL compile in leading-zero blanking: zero nibbles above the highest non-zero snapshot nibble drive seg=1111111; digit 0 never blanked; dp unaffected.
REQ-026 Without SEG7_LZB_EN every digit SHALL display its hex glyph, and no blanking logic SHALL be synthesised.

Structure
REQ-027 Package seg7_pkg SHALL hold the 16-entry glyph table, SEG_BLANK=7'b1111111 and the index-width function max(1,clog2(NUM_DIGITS)).
REQ-028 Sub-module hex_to_seg7 (combinational, 4-bit in, 7-bit out, table from seg7_pkg) SHALL perform the decode.

Verification (NUM_DIGITS=4, CLK_DIV=8, GUARD_CYCLES=2)
REQ-029 Reset then value=16'h12AF, dp_in=0, digit_en=F -> after first wrap an cycles 1110,1101,1011,0111 every 8 cycles; seg per slot 0111000, 0001000, 0010010, 1001111.
REQ-030 Cycles 0-1 of each slot -> an=1111; cycles 2-7 -> one anode low; frame_done single-cycle every 32 cycles.
REQ-031 value changes 16'h1111->16'h2222 while idx=1 -> digits 2,3 still show 1 this frame; all show 2 the next frame.
REQ-032 digit_en=4'b1010, dp_in=4'b0001 -> an never drives bits 0 or 2 low; dp=0 only in slot 0.
REQ-033 rst_n low for one cycle at idx=2, cnt=5 -> next cycle an=1111, seg=1111111, frame_done=0; scan restarts at idx=0.
REQ-034 With SEG7_LZB_EN, value=16'h0040 -> slots 3,2 seg=1111111, slot 1 seg=1001100, slot 0 seg=0000001; value=0 -> only slot 0 shows 0000001.
